// File: rtl/ece241_q4_seq_ctrl.sv
// Sequencer that clears, drives and observes a private three-flop datapath,
// counting the cycles in which its output z is high and reporting via done/ack.
module ece241_q4_seq_ctrl #(
  parameter int unsigned PAT_W = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] len,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic             x_out,
  output logic             z_obs,
  output logic [CNT_W-1:0] z_count,
  output logic             z_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [2:0]         q_q, q_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               x_q, x_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               z_c;
  logic [2:0]         q_upd_c;

  // Datapath: q_q = {q1, q2, q3}
  assign z_c     = ~(|q_q);
  assign q_upd_c = {x_q ^ q_q[2], x_q & ~q_q[1], x_q | ~q_q[0]};

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      pat_q   <= '0;
      rem_q   <= '0;
      q_q     <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // pat_q shifts right so bit 0 always holds the next x to apply;
  // rem_q counts the RUN cycles still to go.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    rem_d   = rem_q;
    q_d     = q_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d   = pattern;
          rem_d   = (len > CNT_W'(PAT_W)) ? CNT_W'(PAT_W) : len;
          x_d     = 1'b0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        q_d   = 3'b000;
        cnt_d = '0;
        if (rem_q == '0) begin
          last_d  = 1'b1;
          x_d     = 1'b0;
          state_d = DONE;
        end else begin
          x_d     = pat_q[0];
          pat_d   = pat_q >> 1;
          state_d = RUN;
        end
      end
      RUN: begin
        q_d   = q_upd_c;
        rem_d = rem_q - CNT_W'(1);
        if (z_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (rem_q == CNT_W'(1)) begin
          last_d  = ~(|q_upd_c);
          x_d     = 1'b0;
          state_d = DONE;
        end else begin
          x_d   = pat_q[0];
          pat_d = pat_q >> 1;
        end
      end
      DONE: begin
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CLEAR) || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign x_out   = x_q;
  assign z_obs   = z_c;
  assign z_count = cnt_q;
  assign z_last  = last_q;

endmodule

// File: tb/tb_ece241_q4_seq_ctrl.sv
// Scoreboard bench for ece241_q4_seq_ctrl: stimulus queues expected results,
// a monitor checks them whenever done rises.
module tb_ece241_q4_seq_ctrl;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        start;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic        ack;
  logic        busy, done, x_out, z_obs, z_last;
  logic [4:0]  z_count;

  typedef struct {
    logic [4:0] cnt;
    logic       last;
    int         done_at;
  } exp_t;

  exp_t sb[$];
  int   n_pass   = 0;
  int   n_tot    = 0;
  int   edge_cnt = 0;
  logic done_prev = 1'b0;

  ece241_q4_seq_ctrl #(.PAT_W(16), .CNT_W(5)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .ack     (ack),
    .busy    (busy),
    .done    (done),
    .x_out   (x_out),
    .z_obs   (z_obs),
    .z_count (z_count),
    .z_last  (z_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Monitor: each rising done is matched against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          check("z_count", 32'(z_count), 32'(e.cnt));
          check("z_last", 32'(z_last), 32'(e.last));
          check("done_latency", 32'(edge_cnt), 32'(e.done_at));
        end
      end
      done_prev = done;
    end
  end

  task automatic run(input logic [15:0] pat, input logic [4:0] ln,
                     input logic [15:0] exp_z, input logic [4:0] exp_cnt,
                     input logic exp_last, input bit poke, input int hold);
    int          L;
    int          nbusy;
    int          i;
    logic [15:0] xs, zs, mask;
    logic [4:0]  zc_h;
    logic        zl_h;
    logic        stable;
    L    = (ln > 5'd16) ? 16 : int'(ln);
    mask = (L == 16) ? 16'hFFFF : 16'((32'd1 << L) - 32'd1);
    @(negedge clk);
    pattern = pat;
    len     = ln;
    start   = 1'b1;
    // start edge is edge_cnt+1; done first visible after edge start+1+L
    sb.push_back('{exp_cnt, exp_last, edge_cnt + 2 + L});
    @(negedge clk);
    start   = 1'b0;
    pattern = ~pat;
    len     = 5'd3;
    check("clear_busy", 32'(busy), 32'd1);
    check("clear_x", 32'(x_out), 32'd0);
    nbusy = 1;
    xs    = '0;
    zs    = '0;
    i     = 0;
    while (!done && i < 40) begin
      @(posedge clk);
      #1;
      if (busy) nbusy++;
      if (busy && i < 16) begin
        xs[i] = x_out;
        zs[i] = z_obs;
      end
      if (poke && i == 1) begin
        start = 1'b1;
        ack   = 1'b1;
      end else begin
        start = 1'b0;
        ack   = 1'b0;
      end
      i++;
    end
    start = 1'b0;
    ack   = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    check("busy_cycles", 32'(nbusy), 32'(L + 1));
    check("x_seq", 32'(xs), 32'(pat & mask));
    check("z_seq", 32'(zs), 32'(exp_z));
    zc_h   = z_count;
    zl_h   = z_last;
    stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (!done || busy || z_count !== zc_h || z_last !== zl_h) stable = 1'b0;
      start = poke && (k == 2);
    end
    start = 1'b0;
    if (hold > 0) check("done_hold", 32'(stable), 32'd1);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack_idle", 32'({busy, done}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    start   = 1'b0;
    ack     = 1'b0;
    pattern = '0;
    len     = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_x", 32'(x_out), 32'd0);
    check("rst_zcount", 32'(z_count), 32'd0);
    check("rst_zlast", 32'(z_last), 32'd0);
    check("rst_zobs", 32'(z_obs), 32'd1);
    @(negedge clk);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);

    run(16'h0000, 5'd4,  16'h0005, 5'd2, 1'b1, 1'b0, 0);
    run(16'h000F, 5'd4,  16'h0001, 5'd1, 1'b0, 1'b0, 0);
    run(16'h0001, 5'd4,  16'h0001, 5'd1, 1'b0, 1'b0, 0);
    run(16'hFFFF, 5'd3,  16'h0001, 5'd1, 1'b0, 1'b0, 0);
    run(16'h0000, 5'd0,  16'h0000, 5'd0, 1'b1, 1'b0, 0);
    run(16'h0000, 5'd31, 16'h5555, 5'd8, 1'b1, 1'b0, 0);
    run(16'h000F, 5'd4,  16'h0001, 5'd1, 1'b0, 1'b1, 12);
    run(16'h0000, 5'd4,  16'h0005, 5'd2, 1'b1, 1'b0, 0);

    // Reset in the middle of a run: by now z_count=1 and q=111
    @(negedge clk);
    pattern = 16'h000F;
    len     = 5'd8;
    start   = 1'b1;
    sb.push_back('{5'd0, 1'b0, 0});
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_abort_busy", 32'(busy), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    void'(sb.pop_back());
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_zcount", 32'(z_count), 32'd0);
    check("abort_zobs", 32'(z_obs), 32'd1);
    @(negedge clk);
    aresetn = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done), 32'd0);

    run(16'h0001, 5'd4, 16'h0001, 5'd1, 1'b0, 1'b0, 0);

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
